// File: rtl/ltoh_xfer_sched.sv
// Round-robin scheduler that shares one slow-to-fast transfer channel between NREQ
// requesters. A granted word is held on the channel until a capture slot or a hold timeout.
module ltoh_xfer_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int NREQ       = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                       i_rclk,
  input  logic                       i_rst,
  input  logic [NREQ-1:0]            i_req,
  input  logic [NREQ*DATA_WIDTH-1:0] i_req_data,
  input  logic                       i_slot,
  input  logic                       i_err_clr,
  output logic [NREQ-1:0]            o_gnt,
  output logic [DATA_WIDTH-1:0]      o_ch_data,
  output logic                       o_ch_valid,
  output logic [$clog2(NREQ)-1:0]    o_ch_owner,
  output logic                       o_timeout_err,
  output logic [15:0]                o_xfer_cnt
);

  localparam int IDXW = $clog2(NREQ);
  localparam int CNTW = $clog2(TIMEOUT + 1);
  localparam logic [CNTW-1:0] WAIT_LAST = CNTW'(TIMEOUT - 1);
  localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(NREQ - 1);
  localparam logic [IDXW:0]   NREQ_EXT  = (IDXW + 1)'(NREQ);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [IDXW-1:0]         r_ptr;
  logic [IDXW-1:0]         w_ptr_next;
  logic [CNTW-1:0]         r_wait_cnt;
  logic [CNTW-1:0]         w_wait_cnt_next;
  logic [NREQ-1:0]         r_gnt;
  logic [NREQ-1:0]         w_gnt_next;
  logic [DATA_WIDTH-1:0]   r_ch_data;
  logic [DATA_WIDTH-1:0]   w_ch_data_next;
  logic                    r_ch_valid;
  logic                    w_ch_valid_next;
  logic [IDXW-1:0]         r_ch_owner;
  logic [IDXW-1:0]         w_ch_owner_next;
  logic                    r_timeout_err;
  logic                    w_timeout_err_next;
  logic [15:0]             r_xfer_cnt;
  logic [15:0]             w_xfer_cnt_next;

  logic [DATA_WIDTH-1:0]   w_req_word [NREQ];
  logic [IDXW-1:0]         w_rot_idx  [NREQ];
  logic [NREQ-1:0]         w_rot_req;
  logic                    w_sel_found;
  logic [IDXW-1:0]         w_sel_idx;
  logic [IDXW-1:0]         w_owner_inc;

  // Position gi of the rotated view is requester (ptr + gi) mod NREQ.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
    logic [IDXW:0] w_sum;
    assign w_req_word[gi] = i_req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    assign w_sum          = {1'b0, r_ptr} + (IDXW + 1)'(gi);
    assign w_rot_idx[gi]  = (w_sum >= NREQ_EXT) ? IDXW'(w_sum - NREQ_EXT) : w_sum[IDXW-1:0];
    assign w_rot_req[gi]  = i_req[w_rot_idx[gi]];
  end

  // Scan from the far end so the lowest rotated position wins.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot_req[k]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = w_rot_idx[k];
      end
    end
  end

  assign w_owner_inc = (r_ch_owner == IDX_LAST) ? '0 : r_ch_owner + IDXW'(1);

  always_ff @(posedge i_rclk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_ptr_next         = r_ptr;
    w_wait_cnt_next    = r_wait_cnt;
    w_gnt_next         = '0;
    w_ch_data_next     = r_ch_data;
    w_ch_valid_next    = r_ch_valid;
    w_ch_owner_next    = r_ch_owner;
    w_timeout_err_next = r_timeout_err & ~i_err_clr;
    w_xfer_cnt_next    = r_xfer_cnt;

    case (r_state)
      S_IDLE: begin
        if (w_sel_found) begin
          w_ch_data_next        = w_req_word[w_sel_idx];
          w_ch_owner_next       = w_sel_idx;
          w_ch_valid_next       = 1'b1;
          w_gnt_next[w_sel_idx] = 1'b1;
          w_wait_cnt_next       = '0;
          w_state_next          = S_HOLD;
        end
      end
      S_HOLD: begin
        // A slot on the timeout cycle still completes the transfer.
        if (i_slot) begin
          w_ch_valid_next = 1'b0;
          w_xfer_cnt_next = r_xfer_cnt + 16'd1;
          w_ptr_next      = w_owner_inc;
          w_state_next    = S_IDLE;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_ch_valid_next    = 1'b0;
          w_timeout_err_next = 1'b1;
          w_ptr_next         = w_owner_inc;
          w_state_next       = S_IDLE;
        end else begin
          w_wait_cnt_next = r_wait_cnt + CNTW'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_rclk) begin
    if (i_rst) begin
      r_ptr         <= '0;
      r_wait_cnt    <= '0;
      r_gnt         <= '0;
      r_ch_data     <= '0;
      r_ch_valid    <= 1'b0;
      r_ch_owner    <= '0;
      r_timeout_err <= 1'b0;
      r_xfer_cnt    <= '0;
    end else begin
      r_ptr         <= w_ptr_next;
      r_wait_cnt    <= w_wait_cnt_next;
      r_gnt         <= w_gnt_next;
      r_ch_data     <= w_ch_data_next;
      r_ch_valid    <= w_ch_valid_next;
      r_ch_owner    <= w_ch_owner_next;
      r_timeout_err <= w_timeout_err_next;
      r_xfer_cnt    <= w_xfer_cnt_next;
    end
  end

  assign o_gnt         = r_gnt;
  assign o_ch_data     = r_ch_data;
  assign o_ch_valid    = r_ch_valid;
  assign o_ch_owner    = r_ch_owner;
  assign o_timeout_err = r_timeout_err;
  assign o_xfer_cnt    = r_xfer_cnt;

endmodule

// File: tb/tb_ltoh_xfer_sched.sv
// Bench for ltoh_xfer_sched: directed scenarios plus randomized transactions checked
// against a transaction-level round-robin / slot-or-timeout model.
module tb_ltoh_xfer_sched;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int T  = 64;
  localparam int OW = $clog2(N);

  logic            rclk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic            slot;
  logic            err_clr;
  logic [N-1:0]    gnt;
  logic [DW-1:0]   ch_data;
  logic            ch_valid;
  logic [OW-1:0]   ch_owner;
  logic            timeout_err;
  logic [15:0]     xfer_cnt;

  int errors = 0;
  int checks = 0;
  int exp_ptr = 0;
  int exp_cnt = 0;
  logic exp_err = 1'b0;
  logic [DW-1:0] words [N];

  ltoh_xfer_sched #(.DATA_WIDTH(DW), .NREQ(N), .TIMEOUT(T)) dut (
    .i_rclk(rclk), .i_rst(rst), .i_req(req), .i_req_data(req_data),
    .i_slot(slot), .i_err_clr(err_clr), .o_gnt(gnt), .o_ch_data(ch_data),
    .o_ch_valid(ch_valid), .o_ch_owner(ch_owner), .o_timeout_err(timeout_err),
    .o_xfer_cnt(xfer_cnt)
  );

  always #5 rclk = ~rclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic pulse_slot();
    slot = 1'b1;
    tick();
    slot = 1'b0;
  endtask

  task automatic load_words();
    for (int i = 0; i < N; i++) begin
      words[i] = $urandom;
      req_data[i*DW +: DW] = words[i];
    end
  endtask

  // First requester at or after start, wrapping upward.
  function automatic int rr_pick(input logic [N-1:0] mask, input int start);
    for (int k = 0; k < N; k++) begin
      if (mask[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int idx);
    logic [N-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1; req = '1; slot = 1'b0; err_clr = 1'b0;
    load_words();
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if ({gnt, ch_valid, ch_owner, timeout_err, xfer_cnt, ch_data} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got gnt=%b valid=%b owner=%0d err=%b cnt=%0d data=%h required all 0",
                 gnt, ch_valid, ch_owner, timeout_err, xfer_cnt, ch_data);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (gnt !== 4'b0001 || ch_owner !== OW'(0) || ch_valid !== 1'b1 || ch_data !== words[0]) begin
      errors++;
      $display("FAIL reset_first_grant: got gnt=%b owner=%0d valid=%b data=%h required gnt=0001 owner=0 valid=1 data=%h",
               gnt, ch_owner, ch_valid, ch_data, words[0]);
    end
    req = '0;
    pulse_slot();
    checks++;
    if (ch_valid !== 1'b0 || xfer_cnt !== 16'd1) begin
      errors++;
      $display("FAIL reset_first_xfer: got valid=%b cnt=%0d required valid=0 cnt=1", ch_valid, xfer_cnt);
    end
    exp_cnt = 1;
    exp_ptr = 1;
    $display("reset test done");
  endtask

  task automatic test_single();
    load_words();
    words[2] = 32'hA5A5_0001;
    req_data[95:64] = words[2];
    req = 4'b0100;
    tick();
    req = '0;
    checks++;
    if (gnt !== 4'b0100) begin
      errors++; $display("FAIL single_gnt: got %b required 0100", gnt);
    end
    checks++;
    if (ch_valid !== 1'b1) begin
      errors++; $display("FAIL single_valid: got %b required 1", ch_valid);
    end
    checks++;
    if (ch_data !== 32'hA5A5_0001) begin
      errors++; $display("FAIL single_data: got %h required a5a50001", ch_data);
    end
    checks++;
    if (ch_owner !== OW'(2)) begin
      errors++; $display("FAIL single_owner: got %0d required 2", ch_owner);
    end
    repeat (9) tick();
    checks++;
    if (ch_valid !== 1'b1 || gnt !== '0) begin
      errors++; $display("FAIL single_hold: got valid=%b gnt=%b required valid=1 gnt=0", ch_valid, gnt);
    end
    pulse_slot();
    checks++;
    if (ch_valid !== 1'b0 || xfer_cnt !== 16'(exp_cnt + 1)) begin
      errors++;
      $display("FAIL single_done: got valid=%b cnt=%0d required valid=0 cnt=%0d", ch_valid, xfer_cnt, exp_cnt + 1);
    end
    exp_cnt++;
    exp_ptr = 3;
    $display("single transfer: owner=2 data=a5a50001");
  endtask

  task automatic test_round_robin();
    int q[$];
    int p;
    rst = 1'b1; tick(); rst = 1'b0;
    exp_cnt = 0; exp_ptr = 0; exp_err = 1'b0;
    load_words();
    req = '1;
    for (int c = 1; c <= 27; c++) begin
      tick();
      if (gnt !== '0) begin
        q.push_back(int'(ch_owner));
        checks++;
        if (gnt !== onehot(int'(ch_owner)) || ch_data !== words[ch_owner]) begin
          errors++;
          $display("FAIL rr_grant_data: got gnt=%b owner=%0d data=%h", gnt, ch_owner, ch_data);
        end
      end
      slot = (c % 5 == 0 && c <= 25);
      if (c == 26) req = '0;
    end
    checks++;
    if (q.size() != 5) begin
      errors++; $display("FAIL rr_grant_count: got %0d required 5", q.size());
    end
    p = 0;
    for (int i = 0; i < 5 && i < q.size(); i++) begin
      checks++;
      if (q[i] != rr_pick('1, p)) begin
        errors++; $display("FAIL rr_order_%0d: got %0d required %0d", i, q[i], rr_pick('1, p));
      end
      p = (rr_pick('1, p) + 1) % N;
    end
    checks++;
    if (xfer_cnt !== 16'd5 || ch_valid !== 1'b0) begin
      errors++; $display("FAIL rr_cnt: got cnt=%0d valid=%b required cnt=5 valid=0", xfer_cnt, ch_valid);
    end
    exp_cnt = 5;
    exp_ptr = 1;
    $display("round robin: %0d grants", q.size());
  endtask

  task automatic test_timeout();
    int hi;
    load_words();
    req = 4'b0001;
    tick();
    req = '0;
    checks++;
    if (gnt !== 4'b0001) begin
      errors++; $display("FAIL to_gnt: got %b required 0001", gnt);
    end
    hi = 0;
    for (int c = 0; c < T + 10; c++) begin
      if (ch_valid !== 1'b1) break;
      hi++;
      tick();
    end
    checks++;
    if (hi != T) begin
      errors++; $display("FAIL to_valid_cycles: got %0d required %0d", hi, T);
    end
    checks++;
    if (timeout_err !== 1'b1 || xfer_cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL to_err: got err=%b cnt=%0d required err=1 cnt=%0d", timeout_err, xfer_cnt, exp_cnt);
    end
    exp_ptr = 1;
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++; $display("FAIL to_clear: got %b required 0", timeout_err);
    end
    // err_clr held through a second timeout: the set must win on the timeout edge.
    err_clr = 1'b1;
    req = 4'b0010;
    tick();
    req = '0;
    repeat (T - 1) tick();
    checks++;
    if (ch_valid !== 1'b1 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL to2_before: got valid=%b err=%b required valid=1 err=0", ch_valid, timeout_err);
    end
    tick();
    checks++;
    if (ch_valid !== 1'b0 || timeout_err !== 1'b1) begin
      errors++; $display("FAIL to2_set_wins: got valid=%b err=%b required valid=0 err=1", ch_valid, timeout_err);
    end
    tick();
    err_clr = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++; $display("FAIL to2_clear: got %b required 0", timeout_err);
    end
    exp_ptr = 2;
    exp_err = 1'b0;
    $display("timeout test: valid cycles=%0d", hi);
  endtask

  task automatic test_race();
    load_words();
    req = 4'b0100;
    tick();
    req = '0;
    repeat (T - 1) tick();
    slot = 1'b1; tick(); slot = 1'b0;
    checks++;
    if (ch_valid !== 1'b0 || xfer_cnt !== 16'(exp_cnt + 1) || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL race_slot_wins: got valid=%b cnt=%0d err=%b required valid=0 cnt=%0d err=0",
               ch_valid, xfer_cnt, timeout_err, exp_cnt + 1);
    end
    exp_cnt++;
    exp_ptr = 3;
    req = 4'b1000;
    slot = 1'b1;
    tick();
    slot = 1'b0;
    req = '0;
    checks++;
    if (gnt !== 4'b1000 || ch_valid !== 1'b1) begin
      errors++; $display("FAIL race_grant_slot: got gnt=%b valid=%b required gnt=1000 valid=1", gnt, ch_valid);
    end
    repeat (3) tick();
    checks++;
    if (ch_valid !== 1'b1 || xfer_cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL race_slot_ignored: got valid=%b cnt=%0d required valid=1 cnt=%0d", ch_valid, xfer_cnt, exp_cnt);
    end
    pulse_slot();
    checks++;
    if (ch_valid !== 1'b0 || xfer_cnt !== 16'(exp_cnt + 1)) begin
      errors++;
      $display("FAIL race_next_slot: got valid=%b cnt=%0d required valid=0 cnt=%0d", ch_valid, xfer_cnt, exp_cnt + 1);
    end
    exp_cnt++;
    exp_ptr = 0;
    $display("race test done");
  endtask

  task automatic test_reset_mid_hold();
    load_words();
    req = 4'b0100;
    tick();
    req = '0;
    pulse_slot();
    exp_cnt++;
    exp_ptr = 3;
    req = 4'b1100;
    tick();
    checks++;
    if (gnt !== onehot(rr_pick(4'b1100, exp_ptr))) begin
      errors++; $display("FAIL rmh_pre_gnt: got %b required %b", gnt, onehot(rr_pick(4'b1100, exp_ptr)));
    end
    repeat (3) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (ch_valid !== 1'b0 || gnt !== '0 || xfer_cnt !== 16'd0 || timeout_err !== 1'b0 || ch_owner !== OW'(0)) begin
      errors++;
      $display("FAIL rmh_reset: got valid=%b gnt=%b cnt=%0d err=%b owner=%0d required all 0",
               ch_valid, gnt, xfer_cnt, timeout_err, ch_owner);
    end
    rst = 1'b0;
    exp_cnt = 0; exp_ptr = 0; exp_err = 1'b0;
    tick();
    checks++;
    if (gnt !== onehot(rr_pick(4'b1100, 0)) || ch_data !== words[rr_pick(4'b1100, 0)]) begin
      errors++;
      $display("FAIL rmh_regrant: got gnt=%b data=%h required gnt=%b", gnt, ch_data, onehot(rr_pick(4'b1100, 0)));
    end
    req = '0;
    pulse_slot();
    checks++;
    if (xfer_cnt !== 16'd1 || ch_valid !== 1'b0) begin
      errors++; $display("FAIL rmh_done: got cnt=%0d valid=%b required cnt=1 valid=0", xfer_cnt, ch_valid);
    end
    exp_cnt = 1;
    exp_ptr = 3;
    $display("reset mid-hold test done");
  endtask

  task automatic test_random();
    logic [N-1:0] mask;
    int w;
    int d;
    for (int t = 0; t < 40; t++) begin
      load_words();
      mask = N'($urandom_range(1, (1 << N) - 1));
      d = ($urandom_range(0, 3) == 0) ? $urandom_range(T - 2, T + 3) : $urandom_range(0, 20);
      w = rr_pick(mask, exp_ptr);
      req = mask;
      tick();
      req = '0;
      checks++;
      if (gnt !== onehot(w) || ch_owner !== OW'(w) || ch_data !== words[w] || ch_valid !== 1'b1) begin
        errors++;
        $display("FAIL rand_grant_%0d: got gnt=%b owner=%0d data=%h valid=%b required gnt=%b owner=%0d data=%h",
                 t, gnt, ch_owner, ch_data, ch_valid, onehot(w), w, words[w]);
      end
      repeat (d) tick();
      checks++;
      if (ch_valid !== (d < T)) begin
        errors++; $display("FAIL rand_hold_%0d: got valid=%b required %b", t, ch_valid, (d < T));
      end
      pulse_slot();
      if (d < T) exp_cnt++;
      else exp_err = 1'b1;
      exp_ptr = (w + 1) % N;
      checks++;
      if (ch_valid !== 1'b0 || xfer_cnt !== 16'(exp_cnt) || timeout_err !== exp_err) begin
        errors++;
        $display("FAIL rand_done_%0d: got valid=%b cnt=%0d err=%b required valid=0 cnt=%0d err=%b",
                 t, ch_valid, xfer_cnt, timeout_err, exp_cnt, exp_err);
      end
      $display("txn %0d: mask=%b owner=%0d delay=%0d %s", t, mask, w, d, (d < T) ? "slot" : "timeout");
      if ($urandom_range(0, 3) == 0) begin
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        exp_err = 1'b0;
        checks++;
        if (timeout_err !== 1'b0) begin
          errors++; $display("FAIL rand_clr_%0d: got %b required 0", t, timeout_err);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; req_data = '0; slot = 1'b0; err_clr = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_race();
    test_reset_mid_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
